// File: rtl/uart_rx_parity_unit.sv
// uart_rx_parity_unit
//   UART RX parity checker. Accumulates parity serially while the data bits are
//   sampled, then compares the received parity bit at the mid-bit sample point.
//   Even/odd/mark/space parity, DATA_WIDTH data bits per frame.
//
// Optional feature: define UART_PAR_ERR_CNT_EN to add a saturating parity-error
//   counter (err_count, cleared by err_cnt_clr). Without it those ports are absent.
//
// Ports
//   clk              in   system clock, rising edge
//   rst              in   asynchronous reset, active-high
//   par_typ          in   2'b00 even, 01 odd, 10 mark, 11 space
//   prescale         in   oversampling ratio (8, 16 or 32)
//   edge_count       in   oversample edge index within the current bit
//   sampled_bit      in   majority-sampled bit from the sampler
//   frame_start      in   1-cycle pulse: start bit accepted, begin a new frame
//   data_bit_en      in   RX FSM is in its data-bit phase
//   parity_check_en  in   RX FSM is in its parity-bit phase
//   calc_par         out  expected parity bit (combinational from registers)
//   par_done         out  1-cycle pulse: parity compare performed
//   par_err          out  result of the last compare (1 = mismatch)
//   err_count        out  saturating mismatch count (optional)
//   err_cnt_clr      in   synchronous clear of err_count (optional)

module uart_rx_parity_unit #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRESCALE_W = 6
`ifdef UART_PAR_ERR_CNT_EN
  ,
  parameter int unsigned CNT_W      = 8
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            par_typ,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [PRESCALE_W-1:0] edge_count,
  input  logic                  sampled_bit,
  input  logic                  frame_start,
  input  logic                  data_bit_en,
  input  logic                  parity_check_en,
  output logic                  calc_par,
  output logic                  par_done,
  output logic                  par_err
`ifdef UART_PAR_ERR_CNT_EN
  ,
  output logic [CNT_W-1:0]      err_count,
  input  logic                  err_cnt_clr
`endif
);

  localparam int unsigned BCW = $clog2(DATA_WIDTH + 1);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             acc_q, acc_d;
  logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
  logic             par_err_d, par_done_d;

  logic [PRESCALE_W-1:0] sample_pt;
  logic                  sample_ev;
  logic                  data_ev;
  logic                  par_ev;
  logic                  mismatch;

  // Mid-bit sample point and qualified events; frame_start suppresses any compare.
  assign sample_pt = PRESCALE_W'((prescale >> 1) + PRESCALE_W'(2));
  assign sample_ev = (edge_count == sample_pt);
  assign data_ev   = (state_q == DATA) && data_bit_en && sample_ev && !frame_start;
  assign par_ev    = (state_q == PARITY) && parity_check_en && sample_ev && !frame_start;
  assign mismatch  = (sampled_bit != calc_par);

  // Expected parity bit from the running XOR.
  always_comb begin
    calc_par = acc_q;
    case (par_typ)
      2'b00:   calc_par = acc_q;
      2'b01:   calc_par = ~acc_q;
      2'b10:   calc_par = 1'b1;
      default: calc_par = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; frame_start restarts from any state.
  always_comb begin
    state_d = state_q;
    if (frame_start) begin
      state_d = DATA;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        DATA:    if (data_ev && (bit_cnt_q == LAST_BIT)) state_d = PARITY;
        PARITY:  if (par_ev) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output / datapath next values.
  always_comb begin
    acc_d      = acc_q;
    bit_cnt_d  = bit_cnt_q;
    par_err_d  = par_err;
    par_done_d = 1'b0;
    if (frame_start) begin
      acc_d     = 1'b0;
      bit_cnt_d = '0;
      par_err_d = 1'b0;
    end else if (data_ev) begin
      acc_d     = acc_q ^ sampled_bit;
      bit_cnt_d = bit_cnt_q + BCW'(1);
    end else if (par_ev) begin
      par_err_d  = mismatch;
      par_done_d = 1'b1;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q     <= 1'b0;
      bit_cnt_q <= '0;
      par_err   <= 1'b0;
      par_done  <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      bit_cnt_q <= bit_cnt_d;
      par_err   <= par_err_d;
      par_done  <= par_done_d;
    end
  end

`ifdef UART_PAR_ERR_CNT_EN
  logic [CNT_W-1:0] err_cnt_d;

  // Saturating mismatch counter; clear beats a same-cycle increment.
  always_comb begin
    err_cnt_d = err_count;
    if (err_cnt_clr) begin
      err_cnt_d = '0;
    end else if (par_ev && mismatch && (err_count != {CNT_W{1'b1}})) begin
      err_cnt_d = err_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
    end else begin
      err_count <= err_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_parity_unit.sv
// Testbench for uart_rx_parity_unit: table of full frames plus hand-written
// abort, idle-ignore, async-reset and (optional) error-counter sequences.

module tb_uart_rx_parity_unit;

  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned PRESCALE_W = 6;
`ifdef UART_PAR_ERR_CNT_EN
  localparam int unsigned CNT_W = 2;
`endif

  logic                  clk = 1'b0;
  logic                  rst;
  logic [1:0]            par_typ;
  logic [PRESCALE_W-1:0] prescale;
  logic [PRESCALE_W-1:0] edge_count;
  logic                  sampled_bit;
  logic                  frame_start;
  logic                  data_bit_en;
  logic                  parity_check_en;
  logic                  calc_par;
  logic                  par_done;
  logic                  par_err;
`ifdef UART_PAR_ERR_CNT_EN
  logic [CNT_W-1:0]      err_count;
  logic                  err_cnt_clr;
`endif

  always #5 clk = ~clk;

  uart_rx_parity_unit #(
    .DATA_WIDTH(DATA_WIDTH),
    .PRESCALE_W(PRESCALE_W)
`ifdef UART_PAR_ERR_CNT_EN
    ,
    .CNT_W(CNT_W)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .par_typ(par_typ),
    .prescale(prescale),
    .edge_count(edge_count),
    .sampled_bit(sampled_bit),
    .frame_start(frame_start),
    .data_bit_en(data_bit_en),
    .parity_check_en(parity_check_en),
    .calc_par(calc_par),
    .par_done(par_done),
    .par_err(par_err)
`ifdef UART_PAR_ERR_CNT_EN
    ,
    .err_count(err_count),
    .err_cnt_clr(err_cnt_clr)
`endif
  );

  typedef struct {
    logic [1:0] ptyp;
    logic [7:0] data;
    logic       pbit;
    logic [5:0] presc;
    logic       exp_calc;
    logic       exp_err;
  } vec_t;

  vec_t vecs[10];

  int   total = 0;
  int   bad   = 0;
  int   done_cnt;
  logic last_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock; results of the inputs applied before this edge are visible on return.
  task automatic cycle();
    @(posedge clk);
    #1;
    if (par_done === 1'b1) begin
      done_cnt++;
      last_err = par_err;
    end
  endtask

  // Hold one bit value for a full bit period, sweeping edge_count.
  task automatic send_bit(input logic v, input logic den, input logic pen);
    sampled_bit     = v;
    data_bit_en     = den;
    parity_check_en = pen;
    for (int e = 0; e < int'(prescale); e++) begin
      edge_count = PRESCALE_W'(e);
      cycle();
    end
    edge_count      = '0;
    data_bit_en     = 1'b0;
    parity_check_en = 1'b0;
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    cycle();
    frame_start = 1'b0;
  endtask

  task automatic send_data(input logic [7:0] d, input logic pen);
    for (int i = 0; i < 8; i++) send_bit(d[i], 1'b1, pen);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    par_typ  = v.ptyp;
    prescale = v.presc;
    done_cnt = 0;
    last_err = ~v.exp_err;
    start_frame();
    chk({tag, "_start_clr"}, 32'(par_err), 32'd0);
    send_data(v.data, 1'b0);
    chk({tag, "_calc_par"}, 32'(calc_par), 32'(v.exp_calc));
    chk({tag, "_no_early_done"}, 32'(done_cnt), 32'd0);
    send_bit(v.pbit, 1'b0, 1'b1);
    cycle();
    cycle();
    chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    chk({tag, "_err_at_done"}, 32'(last_err), 32'(v.exp_err));
    chk({tag, "_err_hold"}, 32'(par_err), 32'(v.exp_err));
  endtask

  initial begin
    // ptyp, data, pbit, prescale, exp calc_par, exp par_err
    vecs[0] = '{2'b00, 8'hA5, 1'b0, 6'd8,  1'b0, 1'b0}; // even, popcount 4
    vecs[1] = '{2'b01, 8'hA5, 1'b0, 6'd8,  1'b1, 1'b1}; // odd -> mismatch
    vecs[2] = '{2'b10, 8'h00, 1'b0, 6'd8,  1'b1, 1'b1}; // mark
    vecs[3] = '{2'b11, 8'h00, 1'b0, 6'd8,  1'b0, 1'b0}; // space
    vecs[4] = '{2'b00, 8'h01, 1'b1, 6'd8,  1'b1, 1'b0}; // even, popcount 1
    vecs[5] = '{2'b01, 8'hFF, 1'b1, 6'd8,  1'b1, 1'b0}; // odd, popcount 8
    vecs[6] = '{2'b00, 8'h07, 1'b0, 6'd8,  1'b1, 1'b1}; // even, popcount 3
    vecs[7] = '{2'b11, 8'hFF, 1'b1, 6'd8,  1'b0, 1'b1}; // space, got 1
    vecs[8] = '{2'b00, 8'h3C, 1'b0, 6'd16, 1'b0, 1'b0}; // sample_pt 10
    vecs[9] = '{2'b01, 8'h80, 1'b0, 6'd32, 1'b0, 1'b0}; // sample_pt 18

    rst             = 1'b1;
    par_typ         = 2'b00;
    prescale        = 6'd8;
    edge_count      = '0;
    sampled_bit     = 1'b0;
    frame_start     = 1'b0;
    data_bit_en     = 1'b0;
    parity_check_en = 1'b0;
    done_cnt        = 0;
    last_err        = 1'b0;
`ifdef UART_PAR_ERR_CNT_EN
    err_cnt_clr     = 1'b0;
`endif
    cycle();
    cycle();
    chk("rst_par_done", 32'(par_done), 32'd0);
    chk("rst_par_err", 32'(par_err), 32'd0);
    chk("rst_calc_par", 32'(calc_par), 32'd0);
`ifdef UART_PAR_ERR_CNT_EN
    chk("rst_err_count", 32'(err_count), 32'd0);
`endif
    rst = 1'b0;
    cycle();

    for (int k = 0; k < 10; k++) run_vec(vecs[k], $sformatf("vec%0d", k));

    // Abort after 4 data bits, then a full even frame 0x01 with parity 1.
    run_vec(vecs[1], "pre_abort");
    par_typ  = 2'b00;
    prescale = 6'd8;
    done_cnt = 0;
    start_frame();
    chk("abort_clr_err", 32'(par_err), 32'd0);
    send_bit(1'b1, 1'b1, 1'b0);
    send_bit(1'b0, 1'b1, 1'b0);
    send_bit(1'b0, 1'b1, 1'b0);
    send_bit(1'b0, 1'b1, 1'b0);
    start_frame();
    send_data(8'h01, 1'b1);           // parity_check_en during DATA must be ignored
    chk("abort_calc_par", 32'(calc_par), 32'd1);
    send_bit(1'b1, 1'b0, 1'b1);
    cycle();
    chk("abort_done_cnt", 32'(done_cnt), 32'd1);
    chk("abort_par_err", 32'(par_err), 32'd0);

    // Enables in IDLE are ignored: no compare, accumulator untouched.
    send_bit(1'b1, 1'b1, 1'b1);
    send_bit(1'b0, 1'b1, 1'b1);
    chk("idle_done_cnt", 32'(done_cnt), 32'd1);
    chk("idle_calc_par", 32'(calc_par), 32'd1);

    // Async reset in the middle of the parity bit.
    done_cnt = 0;
    start_frame();
    send_data(8'h01, 1'b0);
    chk("prerst_calc_par", 32'(calc_par), 32'd1);
    sampled_bit     = 1'b0;
    parity_check_en = 1'b1;
    for (int e = 0; e < 3; e++) begin
      edge_count = PRESCALE_W'(e);
      cycle();
    end
    #2;
    rst = 1'b1;
    #1;
    chk("arst_calc_par", 32'(calc_par), 32'd0);
    chk("arst_par_done", 32'(par_done), 32'd0);
    chk("arst_par_err", 32'(par_err), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int e = 3; e < 8; e++) begin
      edge_count = PRESCALE_W'(e);
      cycle();
    end
    parity_check_en = 1'b0;
    cycle();
    chk("arst_no_done", 32'(done_cnt), 32'd0);

`ifdef UART_PAR_ERR_CNT_EN
    // Saturating counter with CNT_W=2.
    err_cnt_clr = 1'b1;
    cycle();
    err_cnt_clr = 1'b0;
    chk("cnt_clr0", 32'(err_count), 32'd0);
    run_vec(vecs[1], "cnt_bad1");
    chk("cnt_one", 32'(err_count), 32'd1);
    run_vec(vecs[0], "cnt_good");
    chk("cnt_good_hold", 32'(err_count), 32'd1);
    for (int n = 0; n < 4; n++) run_vec(vecs[1], "cnt_bad");
    chk("cnt_sat", 32'(err_count), 32'd3);
    err_cnt_clr = 1'b1;
    cycle();
    err_cnt_clr = 1'b0;
    chk("cnt_clr", 32'(err_count), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
